// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: redirect requests, stall, fetch handshake and PC outputs.
// master = the PC generator, slave = the pipeline/memory side that drives it.
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_target;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus;
  logic             adef;

  modport master (
    input  stall, br_valid, br_target, ex_valid, ex_target, fetch_ready,
    output fetch_valid, pc_out, pc_plus, adef
  );

  modport slave (
    output stall, br_valid, br_target, ex_valid, ex_target, fetch_ready,
    input  fetch_valid, pc_out, pc_plus, adef
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: step on accepted fetch, ex/br redirects, post-redirect bubble.
// Optional misaligned-target trap (adef + FAULT state) when PC_ALIGN_CHECK_EN is defined.
module pc_gen #(
  parameter int          WIDTH        = 32,
  parameter int          STEP         = 4,
  parameter int          ALIGN        = 2,
  parameter logic [31:0] RESET_PC     = 32'h1C00_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  pc_gen_if.master     bus
);

  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN;
  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH
`ifdef PC_ALIGN_CHECK_EN
    , ST_FAULT
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             fetch_valid;
  logic             br_take;
  logic             redirect;
  logic [WIDTH-1:0] target;

`ifdef PC_ALIGN_CHECK_EN
  logic             adef_reg, adef_next;
  logic             misaligned;

  // A faulted fetch stream can only be recovered by the exception path.
  assign br_take    = bus.br_valid && (state_reg != ST_FAULT);
  assign misaligned = |(target & ~ALIGN_MASK);
`else
  assign br_take    = bus.br_valid;
`endif

  assign redirect = bus.ex_valid || br_take;
  assign target   = bus.ex_valid ? bus.ex_target : bus.br_target;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    cnt_next    = cnt_reg;
    fetch_valid = (state_reg == ST_RUN) && !bus.stall;
`ifdef PC_ALIGN_CHECK_EN
    adef_next   = adef_reg;
`endif
    if (redirect) begin
      // Redirect beats stall and handshake; the in-flight fetch is not advanced.
      cnt_next   = FLUSH_INIT;
      state_next = (FLUSH_INIT != 4'd0) ? ST_FLUSH : ST_RUN;
`ifdef PC_ALIGN_CHECK_EN
      pc_next    = target;
      adef_next  = misaligned;
      if (misaligned) begin
        state_next = ST_FAULT;
      end
`else
      pc_next    = target & ALIGN_MASK;
`endif
    end else begin
      case (state_reg)
        ST_BOOT: state_next = ST_RUN;
        ST_RUN: begin
          if (fetch_valid && bus.fetch_ready) begin
            pc_next = pc_reg + STEP_W;
          end
        end
        ST_FLUSH: begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) begin
            state_next = ST_RUN;
          end
        end
`ifdef PC_ALIGN_CHECK_EN
        ST_FAULT: state_next = ST_FAULT;
`endif
        default: state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_BOOT;
      pc_reg    <= RESET_PC_W;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adef_reg <= 1'b0;
    end else begin
      adef_reg <= adef_next;
    end
  end
  assign bus.adef = adef_reg;
`else
  assign bus.adef = 1'b0;
`endif

  assign bus.fetch_valid = fetch_valid;
  assign bus.pc_out      = pc_reg;
  assign bus.pc_plus     = pc_reg + STEP_W;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (FLUSH_CYCLES = 3); expectations adapt to PC_ALIGN_CHECK_EN.
module tb_pc_gen;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pc_gen_if #(.WIDTH(32)) bus ();

  pc_gen #(
    .WIDTH(32), .STEP(4), .ALIGN(2), .RESET_PC(32'h1C00_0000), .FLUSH_CYCLES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%h plus=%h fv=%b adef=%b", $time, bus.pc_out, bus.pc_plus, bus.fetch_valid, bus.adef);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0; bus.br_valid = 1'b0; bus.ex_valid = 1'b0;
    bus.br_target = '0; bus.ex_target = '0; bus.fetch_ready = 1'b1;
    tick(); tick();
    checks++; if (bus.pc_out !== 32'h1C000000) begin errors++; $display("FAIL reset_pc: got %h want 1c000000", bus.pc_out); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", bus.fetch_valid); end
    checks++; if (bus.adef !== 1'b0) begin errors++; $display("FAIL reset_adef: got %b want 0", bus.adef); end
    rst = 1'b0;
    #1;
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_fv: got %b want 0", bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_valid !== 1'b1 || bus.pc_out !== 32'h1C000000) begin errors++; $display("FAIL run0: got fv=%b pc=%h want 1 1c000000", bus.fetch_valid, bus.pc_out); end
    checks++; if (bus.pc_plus !== 32'h1C000004) begin errors++; $display("FAIL pc_plus: got %h want 1c000004", bus.pc_plus); end
    tick();
    checks++; if (bus.pc_out !== 32'h1C000004) begin errors++; $display("FAIL run1: got %h want 1c000004", bus.pc_out); end
    tick();
    checks++; if (bus.pc_out !== 32'h1C000008) begin errors++; $display("FAIL run2: got %h want 1c000008", bus.pc_out); end
  endtask

  task automatic test_handshake();
    bus.fetch_ready = 1'b0;
    tick();
    checks++; if (bus.pc_out !== 32'h1C000008) begin errors++; $display("FAIL not_ready_hold: got %h want 1c000008", bus.pc_out); end
    bus.fetch_ready = 1'b1;
    tick();
    checks++; if (bus.pc_out !== 32'h1C00000C) begin errors++; $display("FAIL ready_adv: got %h want 1c00000c", bus.pc_out); end
    bus.stall = 1'b1;
    #1;
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv: got %b want 0", bus.fetch_valid); end
    tick();
    checks++; if (bus.pc_out !== 32'h1C00000C || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall1: got pc=%h fv=%b want 1c00000c 0", bus.pc_out, bus.fetch_valid); end
    tick();
    checks++; if (bus.pc_out !== 32'h1C00000C || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall2: got pc=%h fv=%b want 1c00000c 0", bus.pc_out, bus.fetch_valid); end
    bus.stall = 1'b0;
    #1;
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL unstall_fv: got %b want 1", bus.fetch_valid); end
    tick();
    checks++; if (bus.pc_out !== 32'h1C000010) begin errors++; $display("FAIL unstall_adv: got %h want 1c000010", bus.pc_out); end
  endtask

  task automatic test_redirect();
    bus.br_valid = 1'b1; bus.br_target = 32'h1C000100;
    bus.ex_valid = 1'b1; bus.ex_target = 32'h1C008000;
    tick();
    bus.br_valid = 1'b0; bus.ex_valid = 1'b0;
    checks++; if (bus.pc_out !== 32'h1C008000 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL ex_priority: got pc=%h fv=%b want 1c008000 0", bus.pc_out, bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL flush_b2: got %b want 0", bus.fetch_valid); end
    // second redirect mid-bubble restarts the full three-cycle bubble
    bus.br_valid = 1'b1; bus.br_target = 32'h00000200;
    tick();
    bus.br_valid = 1'b0;
    checks++; if (bus.pc_out !== 32'h00000200 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reflush_pc: got pc=%h fv=%b want 00000200 0", bus.pc_out, bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reflush_b2: got %b want 0", bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reflush_b3: got %b want 0", bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_valid !== 1'b1 || bus.pc_out !== 32'h00000200) begin errors++; $display("FAIL reflush_run: got fv=%b pc=%h want 1 00000200", bus.fetch_valid, bus.pc_out); end
  endtask

  task automatic test_back_to_back();
    bus.br_valid = 1'b1; bus.br_target = 32'h00001000;
    tick();
    bus.br_valid = 1'b0;
    checks++; if (bus.pc_out !== 32'h00001000) begin errors++; $display("FAIL redirect_wins: got %h want 00001000", bus.pc_out); end
    tick(); tick(); tick();
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL b2b_run: got %b want 1", bus.fetch_valid); end
    tick();
    checks++; if (bus.pc_out !== 32'h00001004) begin errors++; $display("FAIL b2b_adv: got %h want 00001004", bus.pc_out); end
  endtask

  task automatic test_wrap();
    bus.br_valid = 1'b1; bus.br_target = 32'hFFFFFFFC;
    tick();
    bus.br_valid = 1'b0;
    bus.stall = 1'b1;
    tick(); tick(); tick();
    bus.stall = 1'b0;
    #1;
    checks++; if (bus.fetch_valid !== 1'b1 || bus.pc_out !== 32'hFFFFFFFC) begin errors++; $display("FAIL stall_no_extend: got fv=%b pc=%h want 1 fffffffc", bus.fetch_valid, bus.pc_out); end
    checks++; if (bus.pc_plus !== 32'h00000000) begin errors++; $display("FAIL wrap_plus: got %h want 00000000", bus.pc_plus); end
    tick();
    checks++; if (bus.pc_out !== 32'h00000000) begin errors++; $display("FAIL wrap_pc: got %h want 00000000", bus.pc_out); end
  endtask

  task automatic test_align();
    bus.br_valid = 1'b1; bus.br_target = 32'h1C000102;
    tick();
    bus.br_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (bus.pc_out !== 32'h1C000102 || bus.adef !== 1'b1 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL fault_enter: got pc=%h adef=%b fv=%b want 1c000102 1 0", bus.pc_out, bus.adef, bus.fetch_valid); end
    bus.br_valid = 1'b1; bus.br_target = 32'h00000300;
    tick(); tick(); tick(); tick();
    bus.br_valid = 1'b0;
    checks++; if (bus.pc_out !== 32'h1C000102 || bus.adef !== 1'b1 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL fault_hold: got pc=%h adef=%b fv=%b want 1c000102 1 0", bus.pc_out, bus.adef, bus.fetch_valid); end
    bus.ex_valid = 1'b1; bus.ex_target = 32'h1C008000;
    tick();
    bus.ex_valid = 1'b0;
    checks++; if (bus.pc_out !== 32'h1C008000 || bus.adef !== 1'b0) begin errors++; $display("FAIL fault_exit: got pc=%h adef=%b want 1c008000 0", bus.pc_out, bus.adef); end
`else
    checks++; if (bus.pc_out !== 32'h1C000100 || bus.adef !== 1'b0) begin errors++; $display("FAIL align_force: got pc=%h adef=%b want 1c000100 0", bus.pc_out, bus.adef); end
`endif
    tick(); tick(); tick();
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL align_run: got %b want 1", bus.fetch_valid); end
  endtask

  task automatic test_reset_mid();
    bus.br_valid = 1'b1; bus.br_target = 32'h00000400;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.pc_out !== 32'h1C000000 || bus.fetch_valid !== 1'b0 || bus.adef !== 1'b0) begin errors++; $display("FAIL async_reset: got pc=%h fv=%b adef=%b want 1c000000 0 0", bus.pc_out, bus.fetch_valid, bus.adef); end
    tick();
    checks++; if (bus.pc_out !== 32'h1C000000) begin errors++; $display("FAIL reset_discard: got %h want 1c000000", bus.pc_out); end
    rst = 1'b0;
    bus.br_valid = 1'b0;
    #1;
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reboot_fv: got %b want 0", bus.fetch_valid); end
    tick();
    checks++; if (bus.fetch_valid !== 1'b1 || bus.pc_out !== 32'h1C000000) begin errors++; $display("FAIL reboot_run: got fv=%b pc=%h want 1 1c000000", bus.fetch_valid, bus.pc_out); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_align();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the five-stage LA32R pipeline; it replaces the bare PC+4 incrementer feeding the IF stage. It holds the fetch PC in a register and advances it by a configurable step on each accepted fetch. It applies branch and exception redirects with fixed priority, and inserts a programmable post-redirect fetch bubble. It drives the fetch request handshake towards instruction memory.

## Interface
- `WIDTH`, 32: PC width in bits.
- `STEP`, 4: increment applied per accepted fetch.
- `ALIGN`, 2: number of low PC bits that must be zero.
- `RESET_PC`, 32'h1C00_0000: PC value loaded on reset, truncated to `WIDTH`.
- `FLUSH_CYCLES`, 1: bubble cycles after a redirect; legal range 0..15.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `stall`  in  1  hazard-unit stall; suppresses the fetch request and PC advance.
- `br_valid`  in  1  branch/jump redirect request from EX.
- `br_target`  in  WIDTH  branch target.
- `ex_valid`  in  1  exception/ertn redirect request from WB.
- `ex_target`  in  WIDTH  exception entry or return target.
- `fetch_ready`  in  1  instruction memory accepts a request this cycle.
- `fetch_valid`  out  1  fetch request valid.
- `pc_out`  out  WIDTH  current fetch PC, registered.
- `pc_plus`  out  WIDTH  `pc_out + STEP`, combinational, used as the link value.
- `adef`  out  1  misaligned-fetch flag, registered.

## Operation
- States:
  - BOOT: first cycle after reset.
  - RUN: normal fetch.
  - FLUSH: post-redirect bubble.
  - FAULT: misaligned target, only when `PC_ALIGN_CHECK_EN` is defined.
- `fetch_valid` = (state == RUN) && !`stall`.
- A fetch is accepted when `fetch_valid` && `fetch_ready`.
- Redirect selection:
  - `ex_valid` has priority over `br_valid`; the target is `ex_target` when `ex_valid`, else `br_target`.
  - A redirect overrides stall, handshake and PC advance.
  - A redirect is honoured in BOOT, RUN and FLUSH.
  - In FAULT, only `ex_valid` is honoured; `br_valid` is ignored.
- Redirect effect on the next edge:
  - `pc_out` ← target.
  - Bubble counter ← `FLUSH_CYCLES`.
  - Next state is FLUSH if `FLUSH_CYCLES` > 0, else RUN.
- Accepted fetch with no redirect: `pc_out` ← `pc_out + STEP`, modulo 2^`WIDTH`; wrap-around is silent.
- No accepted fetch and no redirect: `pc_out` holds.
- BOOT: `fetch_valid` = 0; moves to RUN unconditionally after one cycle unless redirected.
- FLUSH:
  - `fetch_valid` = 0; the counter decrements each cycle.
  - When the counter equals 1, the next state is RUN.
  - A redirect during FLUSH reloads the counter and restarts the bubble.
- `pc_plus` is valid in every state.

## Timing
- Reset values: `pc_out` = `RESET_PC`, state = BOOT, counter = 0, `fetch_valid` = 0, `adef` = 0.
- Reset asserted mid-operation returns the block to these values immediately; pending redirects are discarded.
- First fetch request is in cycle 2 after reset deassertion: one BOOT cycle, then RUN.
- Redirect latency: request in cycle N → `pc_out` = target in cycle N+1.
  - First `fetch_valid` for the target is in cycle N+1+`FLUSH_CYCLES`, provided `stall` is low.
- Redirect and accepted fetch in the same cycle: the redirect wins and the fetched PC is not incremented.
- `stall` only affects RUN; it does not extend a FLUSH bubble.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A redirect target with any of the low `ALIGN` bits nonzero loads `pc_out` ← target unmodified, sets `adef` = 1 and enters FAULT.
  - FAULT drives `fetch_valid` = 0 and holds until an `ex_valid` redirect.
  - That redirect clears `adef` and follows the normal redirect rules, including re-checking alignment.
- `PC_ALIGN_CHECK_EN` undefined:
  - The low `ALIGN` bits of every redirect target are forced to zero.
  - `adef` is tied to 0 and the FAULT state does not exist.

## Test plan
- Reset release with `fetch_ready` = 1 and `stall` = 0 → `fetch_valid` = 0 in the first cycle; then `pc_out` = 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles.
- `fetch_ready` toggled 1,0,1 and `stall` pulsed for 2 cycles → `pc_out` advances only on accepted cycles; `fetch_valid` = 0 during the stall.
- `br_valid` with `br_target` = 0x1C000100 and `ex_valid` with `ex_target` = 0x1C008000 in the same cycle, `FLUSH_CYCLES` = 3 → `pc_out` = 0x1C008000 next cycle; `fetch_valid` low for exactly 3 cycles.
- Second `br_valid` (target 0x200) during FLUSH → counter restarts; `pc_out` = 0x200.
- `pc_out` = 0xFFFFFFFC, accepted fetch → `pc_out` = 0x00000000.
- Redirect to 0x1C000102:
  - With `PC_ALIGN_CHECK_EN`: `adef` = 1, `fetch_valid` stays 0, and `br_valid` is ignored; a following `ex_valid` to 0x1C008000 clears `adef`.
  - Without the macro: `pc_out` = 0x1C000100 and `adef` = 0.
